game_ctl: RTL and testbench

- Top-level game sequencer for the 1024x768 @ 60 fps two-player game. Runs the START -> GAME -> PLAYER_1/PLAYER_2 state machine using the 2-bit state encoding from vga_pkg.
- Keeps both players' scores and detects the winner.
- Issues a one-cycle init pulse that re-spawns players and points.
- Feeds the draw/overlay modules and gates the movement and point-collection logic.

---
 rtl/game_ctl.sv | 138 +++++++++++++
 tb/tb_game_ctl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctl.sv
`default_nettype none
// game_ctl: START/GAME/PLAYER_x sequencer with scores, win detection and play-field init pulse.
// Optional round timer built only when GAME_TIMER_EN is defined.  Revision 1.0
module game_ctl #(
  parameter int WIN_SCORE      = 10,
  parameter int HOLD_FRAMES    = 60,
  parameter int ROUND_SECONDS  = 99,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       frame_tick,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [1:0] game_state,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_init,
  output logic [6:0] time_left
);

  typedef enum logic [1:0] {
    START    = 2'b00,
    GAME     = 2'b01,
    PLAYER_1 = 2'b11,
    PLAYER_2 = 2'b10
  } state_t;

  localparam int            HW       = $clog2(HOLD_FRAMES + 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  state_t        state, state_nxt;
  logic          btn_armed;
  logic          press;
  logic [3:0]    s1_nxt, s2_nxt;
  logic          init_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          timeout;

  // btn_armed holds the inverted previous button level; clearing it at reset
  // means a button held through reset release is not seen as a press.
  assign press = btn_start & btn_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= START;
      btn_armed <= 1'b0;
      score_p1  <= '0;
      score_p2  <= '0;
      game_init <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      btn_armed <= ~btn_start;
      score_p1  <= s1_nxt;
      score_p2  <= s2_nxt;
      game_init <= init_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s1_nxt    = score_p1;
    s2_nxt    = score_p2;
    init_nxt  = 1'b0;
    hold_nxt  = hold_cnt;
    case (state)
      START: begin
        if (press) begin
          state_nxt = GAME;
          s1_nxt    = '0;
          s2_nxt    = '0;
          init_nxt  = 1'b1;
        end
      end
      GAME: begin
        if (p1_point && (score_p1 < WIN)) s1_nxt = score_p1 + 4'd1;
        if (p2_point && (score_p2 < WIN)) s2_nxt = score_p2 + 4'd1;
        // Win check looks at the registered scores, so a winning point shows up two cycles later.
        if (score_p1 == WIN) begin
          state_nxt = PLAYER_1;
          hold_nxt  = '0;
        end else if (score_p2 == WIN) begin
          state_nxt = PLAYER_2;
          hold_nxt  = '0;
        end else if (timeout) begin
          state_nxt = (score_p1 >= score_p2) ? PLAYER_1 : PLAYER_2;
          hold_nxt  = '0;
        end
      end
      PLAYER_1, PLAYER_2: begin
        if (frame_tick && (hold_cnt != HOLD_MAX)) hold_nxt = hold_cnt + 1'b1;
        if (press && (hold_cnt == HOLD_MAX)) state_nxt = START;
      end
      default: state_nxt = START;
    endcase
  end

  assign game_state = state;

`ifdef GAME_TIMER_EN
  localparam int            PW        = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(FRAMES_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [6:0]    secs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      secs  <= '0;
    end else if ((state == START) && (state_nxt == GAME)) begin
      presc <= '0;
      secs  <= 7'(ROUND_SECONDS);
    end else if ((state == GAME) && frame_tick) begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        if (secs != 7'd0) secs <= secs - 7'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign time_left = secs;
  assign timeout   = (secs == 7'd0);
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{ROUND_SECONDS, FRAMES_PER_SEC};
  assign time_left        = '0;
  assign timeout          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_ctl.sv
`default_nettype none
// tb_game_ctl: directed and random stimulus for game_ctl, checked against a rule-level model.
// Revision 1.0
module tb_game_ctl;

  localparam int WIN   = 10;
  localparam int HOLD  = 60;
  localparam int ROUND = 2;
  localparam int FPS   = 4;
`ifdef GAME_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [1:0] game_state;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_init;
  logic [6:0] time_left;

  game_ctl #(
    .WIN_SCORE      (WIN),
    .HOLD_FRAMES    (HOLD),
    .ROUND_SECONDS  (ROUND),
    .FRAMES_PER_SEC (FPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_start  (btn_start),
    .frame_tick (frame_tick),
    .p1_point   (p1_point),
    .p2_point   (p2_point),
    .game_state (game_state),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .game_init  (game_init),
    .time_left  (time_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase 0=start 1=game 2=player1 won 3=player2 won.
  int m_phase, m_s1, m_s2, m_init, m_hold, m_gframes;
  bit m_prev, m_played;

  task automatic model_reset();
    m_phase = 0; m_s1 = 0; m_s2 = 0; m_init = 0; m_hold = 0;
    m_gframes = 0; m_played = 1'b0;
    m_prev = 1'b1;
  endtask

  function automatic int m_time();
    int t;
    if (!TIMER_EN || !m_played) return 0;
    t = ROUND - m_gframes / FPS;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int m_code();
    case (m_phase)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_step();
    bit press;
    int t, o1, o2;
    press  = btn_start && !m_prev;
    m_prev = btn_start;
    m_init = 0;
    case (m_phase)
      0: if (press) begin
        m_phase = 1; m_s1 = 0; m_s2 = 0; m_init = 1; m_gframes = 0; m_played = 1'b1;
      end
      1: begin
        t = m_time(); o1 = m_s1; o2 = m_s2;
        if (p1_point && m_s1 < WIN) m_s1++;
        if (p2_point && m_s2 < WIN) m_s2++;
        if (o1 == WIN)                 begin m_phase = 2; m_hold = 0; end
        else if (o2 == WIN)            begin m_phase = 3; m_hold = 0; end
        else if (TIMER_EN && t == 0)   begin m_phase = (o1 >= o2) ? 2 : 3; m_hold = 0; end
        if (frame_tick) m_gframes++;
      end
      default: begin
        if (press && m_hold == HOLD) m_phase = 0;
        else if (frame_tick && m_hold < HOLD) m_hold++;
      end
    endcase
  endtask

  task automatic compare_all();
    chk("state", game_state, m_code());
    chk("score_p1", score_p1, m_s1);
    chk("score_p2", score_p2, m_s2);
    chk("game_init", game_init, m_init);
    chk("time_left", time_left, m_time());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic press_btn();
    btn_start = 1'b1; tick();
    btn_start = 1'b0; tick();
  endtask

  task automatic pulses(input int n, input bit a, input bit b);
    for (int i = 0; i < n; i++) begin
      p1_point = a; p2_point = b; tick();
      p1_point = 1'b0; p2_point = 1'b0; tick();
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  initial begin
    model_reset();
    btn_start = 1'b1;
    #13;
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    // Held button and point pulses in START do nothing.
    for (int i = 0; i < 4; i++) begin
      p1_point = 1'b1; p2_point = 1'b1; tick();
    end
    p1_point = 1'b0; p2_point = 1'b0;
    chk("held_btn_no_start", game_state, 0);
    chk("start_no_init", game_init, 0);
    btn_start = 1'b0; tick();
    btn_start = 1'b1; tick();
    chk("enter_game", game_state, 1);
    chk("init_high", game_init, 1);
    btn_start = 1'b0; tick();
    chk("init_one_cycle", game_init, 0);

    // Player 1 wins by score, latency of two cycles.
    pulses(3, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      p1_point = 1'b1; tick(); p1_point = 1'b0;
      if (i < 9) tick();
    end
    chk("p1_ten", score_p1, 10);
    chk("state_lag", game_state, 1);
    tick();
    chk("p1_wins", game_state, 3);
    pulses(3, 1'b1, 1'b1);
    chk("frozen_p1", score_p1, 10);
    chk("frozen_p2", score_p2, 3);
    frames(HOLD);
    press_btn();
    chk("back_start", game_state, 0);

    // Player 2 wins; early press during the hold is ignored.
    press_btn();
    pulses(WIN, 1'b0, 1'b1);
    chk("p2_wins", game_state, 2);
    frames(30);
    press_btn();
    chk("early_press", game_state, 2);
    frames(30);
    press_btn();
    chk("late_press", game_state, 0);
    chk("kept_p2", score_p2, 10);
    press_btn();
    chk("cleared_p2", score_p2, 0);

    // Tie at 9/9 then simultaneous winning points: player 1 has priority.
    pulses(WIN, 1'b1, 1'b1);
    chk("tie_p1", score_p1, 10);
    chk("tie_p2", score_p2, 10);
    chk("tie_winner", game_state, 3);
    frames(HOLD);
    press_btn();

`ifdef GAME_TIMER_EN
    press_btn();
    pulses(1, 1'b1, 1'b0);
    pulses(3, 1'b0, 1'b1);
    chk("timer_load", time_left, ROUND);
    frames(FPS);
    chk("timer_dec", time_left, ROUND - 1);
    frames(FPS);
    chk("timeout_p2", game_state, 2);
    frames(HOLD);
    press_btn();
`endif

    // Asynchronous reset in the middle of a game.
    press_btn();
    pulses(4, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    chk("rst_state", game_state, 0);
    chk("rst_score", score_p1, 0);
    @(negedge clk) rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) btn_start = ~btn_start;
      frame_tick = ($urandom_range(2) == 0);
      p1_point   = ($urandom_range(3) == 0);
      p2_point   = ($urandom_range(3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
